rni_rxlcrd_gen: RTL

RNI_RXLCRD_GEN -- requirements
Module: rni_rxlcrd_gen

---
 rtl/rni_rxlcrd_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/rni_rxlcrd_gen.sv
// rni_rxlcrd_gen: receive-side L-credit generator with link activation FSM
//   clk, rst          : clock, asynchronous active-high reset
//   rxlinkactivereq   : partner requests link activation
//   rxlinkactiveack   : acknowledge, high in ACT/RUN/DEACT
//   rx_flitv          : flit received, consumes one outstanding credit
//   rx_flit_lcrdrtn   : qualifies rx_flitv as a credit return (no buffer write)
//   buf_free          : one buffer slot released downstream
//   rxlcrdv           : one-cycle credit grant pulse
//   lcrd_out_cnt      : credits held by partner
//   free_cnt          : buffer slots not backing any credit
//   link_run          : high in RUN
//   err               : sticky protocol error
module rni_rxlcrd_gen #(
    parameter int BUF_DEPTH        = 4,
    parameter int LCRD_MAX_CNT_VAL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxlinkactivereq,
    output logic       rxlinkactiveack,
    input  logic       rx_flitv,
    input  logic       rx_flit_lcrdrtn,
    input  logic       buf_free,
    output logic       rxlcrdv,
    output logic [3:0] lcrd_out_cnt,
    output logic [3:0] free_cnt,
    output logic       link_run,
    output logic       err
);
    typedef enum logic [1:0] {STOP, ACT, RUN, DEACT} state_t;

    localparam logic [3:0] BUF_D = 4'(BUF_DEPTH);
    localparam logic [3:0] MAX_C = 4'(LCRD_MAX_CNT_VAL);

    state_t     state, state_nxt;
    logic       init_done;
    logic       issue_s0, flit_ok, ret_ok, bf_ok, err_evt;
    logic [4:0] free_sum;
    logic [3:0] free_nxt, out_nxt;

    assign rxlinkactiveack = state != STOP;
    assign link_run        = state == RUN;

    // Until the init cycle has happened the FSM is frozen.
    always_comb begin
        state_nxt = state;
        if (init_done)
            state_nxt = state == STOP ? (rxlinkactivereq ? ACT : STOP) :
                        state == ACT  ? (rxlinkactivereq ? RUN : DEACT) :
                        state == RUN  ? (rxlinkactivereq ? RUN : DEACT) :
                        (lcrd_out_cnt == 4'd0 && !rx_flitv) ? STOP : DEACT;
    end

    // Only flits that consume a real credit move counters; illegal ones just flag err.
    always_comb begin
        issue_s0 = state == RUN && rxlinkactivereq && free_cnt != 4'd0 && lcrd_out_cnt < MAX_C;
        flit_ok  = init_done && rx_flitv && lcrd_out_cnt != 4'd0 && (state == RUN || state == DEACT);
        ret_ok   = flit_ok && rx_flit_lcrdrtn;
        bf_ok    = init_done && buf_free && free_cnt != BUF_D;
        err_evt  = init_done && ((rx_flitv && (lcrd_out_cnt == 4'd0 || state == STOP || state == ACT))
                                 || (buf_free && free_cnt == BUF_D));
        free_sum = {1'b0, free_cnt} + 5'(bf_ok) + 5'(ret_ok) - 5'(issue_s0);
        free_nxt = free_sum > {1'b0, BUF_D} ? BUF_D : free_sum[3:0];
        out_nxt  = lcrd_out_cnt + 4'(issue_s0) - 4'(flit_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= STOP;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done    <= 1'b0;
            rxlcrdv      <= 1'b0;
            lcrd_out_cnt <= 4'd0;
            free_cnt     <= 4'd0;
            err          <= 1'b0;
        end else if (!init_done) begin
            init_done <= 1'b1;
            free_cnt  <= BUF_D;
        end else begin
            rxlcrdv      <= issue_s0;
            lcrd_out_cnt <= out_nxt;
            free_cnt     <= free_nxt;
            err          <= err | err_evt;
        end
    end
endmodule
